// File: rtl/nou_tx_arbiter_pkg.sv
// Shared constants for the tile-side injection arbiter.
// Width macros default here when the including build does not provide them.
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 4
`endif
`ifndef DAT_DAT_WIDTH
`define DAT_DAT_WIDTH 64
`endif
`ifndef RSP_DAT_WIDTH
`define RSP_DAT_WIDTH 32
`endif

package nou_tx_arbiter_pkg;
  localparam int NOU_TX_NUM_SRC = 4;
  localparam int NOU_PERF_CNT_W = 16;
  localparam int NOU_TID_W      = `TID_WIDTH;
  localparam int NOU_TYPE_W     = `TYPE_WIDTH;
  localparam int NOU_DAT_W      = `DAT_DAT_WIDTH;
  localparam int NOU_RSP_W      = `RSP_DAT_WIDTH;
endpackage

// File: rtl/nou_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo NUM_SRC.
// Purely combinational; works for non-power-of-2 NUM_SRC.
module nou_rr_arb
  import nou_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NOU_TX_NUM_SRC,
  localparam int PW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  logic [PW-1:0] idx;

  // scan ptr, ptr+1, .. and latch the first requester found
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_SRC);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nou_tx_arbiter.sv
// Tile-side injection arbiter: NUM_SRC valid/ready sources merged round-robin
// into one flit stream through a 2-entry registered FIFO.
// Optional feature macro: NOU_TX_ARB_PERF_EN (per-source saturating grant counters).
module nou_tx_arbiter
  import nou_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NOU_TX_NUM_SRC,
  parameter int TID_W     = NOU_TID_W,
  parameter int TYPE_W    = NOU_TYPE_W,
  parameter int DAT_WIDTH = NOU_DAT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*TID_W-1:0]      src_tid,
  input  logic [NUM_SRC*TYPE_W-1:0]     src_type,
  input  logic [NUM_SRC*DAT_WIDTH-1:0]  src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [TID_W-1:0]              out_tid,
  output logic [TYPE_W-1:0]             out_type,
  output logic [DAT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          perf_clr,
  output logic [NUM_SRC*NOU_PERF_CNT_W-1:0] perf_grant
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int FW = TID_W + TYPE_W + DAT_WIDTH;

  logic [1:0][FW-1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic               space, push, pop;
  logic [FW-1:0]      push_flit;

  nou_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .req     (src_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // outputs come straight from the head entry, never from src_*
  assign out_valid = (cnt_q != 2'd0);
  assign {out_tid, out_type, out_data} = mem_q[rd_ptr_q];

  // handshake, FIFO bookkeeping and round-robin pointer update
  always_comb begin
    pop       = out_valid & out_ready;
    // popping frees a slot this cycle, so a full FIFO still accepts one flit
    space     = (cnt_q != 2'd2) | pop;
    // rst gate keeps src_ready low while reset is held
    push      = space & gnt_vld & ~rst;
    src_ready = gnt & {NUM_SRC{space & ~rst}};
    push_flit = {src_tid[int'(gnt_idx)*TID_W +: TID_W],
                 src_type[int'(gnt_idx)*TYPE_W +: TYPE_W],
                 src_data[int'(gnt_idx)*DAT_WIDTH +: DAT_WIDTH]};
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q] = push_flit;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    rr_ptr_d  = rr_ptr_q;
    if (push) rr_ptr_d = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + PW'(1);
  end

  // state registers; reset drops any buffered flits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef NOU_TX_ARB_PERF_EN
  logic [NUM_SRC-1:0][NOU_PERF_CNT_W-1:0] perf_q, perf_d;

  // saturating per-source grant counters; clear beats increment
  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (perf_clr)
        perf_d[i] = '0;
      else if (src_valid[i] && src_ready[i] && (perf_q[i] != {NOU_PERF_CNT_W{1'b1}}))
        perf_d[i] = perf_q[i] + NOU_PERF_CNT_W'(1);
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_grant = perf_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_grant      = '0;
`endif

endmodule

// File: tb/tb_nou_tx_arbiter.sv
// Scoreboard bench for nou_tx_arbiter: a queue-based model predicts grants,
// FIFO contents and perf counters; a negedge monitor compares against the DUT.
module tb_nou_tx_arbiter;
  localparam int N  = 4;
  localparam int TW = 8;
  localparam int YW = 4;
  localparam int DW = 64;
  localparam int FW = TW + YW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*TW-1:0] src_tid = '0;
  logic [N*YW-1:0] src_type = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_ready;
  logic [TW-1:0]   out_tid;
  logic [YW-1:0]   out_type;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            perf_clr = 1'b0;
  logic [N*16-1:0] perf_grant;

  always #5 clk = ~clk;

  nou_tx_arbiter #(.NUM_SRC(N), .TID_W(TW), .TYPE_W(YW), .DAT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .src_tid(src_tid), .src_type(src_type), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .out_tid(out_tid), .out_type(out_type),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .perf_clr(perf_clr), .perf_grant(perf_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // source-side state: a flit stays presented until accepted
  logic [FW-1:0] pend_f [N];
  bit            pend_v [N];
  bit            acc    [N];

  // reference model
  logic [FW-1:0] exp_q [$];
  int            m_ptr = 0;
  int            m_perf [N];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare, then advance the model by the coming clock edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_src_ready", 128'(src_ready), 128'(0));
      chk("rst_perf", 128'(perf_grant), 128'(0));
      exp_q.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin m_perf[i] = 0; acc[i] = 0; end
    end else begin
      logic [N*16-1:0] exp_perf;
      logic [N-1:0]    exp_rdy;
      bit              pop, space;
      int              g;
      exp_perf = '0;
`ifdef NOU_TX_ARB_PERF_EN
      for (int i = 0; i < N; i++) exp_perf[i*16 +: 16] = 16'(m_perf[i]);
`endif
      chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_flit", 128'({out_tid, out_type, out_data}), 128'(exp_q[0]));
      chk("perf_grant", 128'(perf_grant), 128'(exp_perf));
      pop   = (exp_q.size() != 0) && out_ready;
      space = (exp_q.size() < 2) || pop;
      g = -1;
      if (space)
        for (int k = 0; k < N; k++)
          if (g < 0 && pend_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("src_ready", 128'(src_ready), 128'(exp_rdy));
      if (pop) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(pend_f[g]);
        acc[g] = 1;
        m_ptr  = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (perf_clr) m_perf[i] = 0;
        else if (i == g && m_perf[i] < 65535) m_perf[i]++;
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i] = pend_v[i];
      {src_tid[i*TW +: TW], src_type[i*YW +: YW], src_data[i*DW +: DW]} = pend_f[i];
    end
  endtask

  task automatic new_flit(int i, bit fixed_tid);
    logic [TW-1:0] t;
    t = fixed_tid ? TW'(i) : TW'($urandom);
    pend_f[i] = {t, YW'($urandom), $urandom, $urandom};
    pend_v[i] = 1;
  endtask

  // modes: 0 idle, 1 all sources (tid=i), 2 src2 only, 3 src0+src3, 4 random, 5 src1 only
  task automatic step(int mode, bit ordy);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) begin pend_v[i] = 0; acc[i] = 0; end
    perf_clr  = 1'b0;
    out_ready = ordy;
    for (int i = 0; i < N; i++) if (!pend_v[i]) begin
      case (mode)
        1: new_flit(i, 1);
        2: if (i == 2) new_flit(i, 0);
        3: if (i == 0 || i == 3) new_flit(i, 0);
        4: if ($urandom_range(1, 0) == 1) new_flit(i, 0);
        5: if (i == 1) new_flit(i, 0);
        default: ;
      endcase
    end
    if (mode == 4) begin
      out_ready = ($urandom_range(3, 0) != 0);
      perf_clr  = ($urandom_range(49, 0) == 0);
    end
    drive();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_f[i] = '0; acc[i] = 0; m_perf[i] = 0; end
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // idle after reset
    repeat (10) step(0, 1'b0);
    // all sources valid, full-rate drain
    repeat (40) step(1, 1'b1);
    repeat (4)  step(0, 1'b1);
    // single source against a stalled output, then release
    repeat (6)  step(2, 1'b0);
    repeat (10) step(2, 1'b1);
    // pointer now sits at 3: sources 3 and 0 alternate
    repeat (12) step(3, 1'b1);
    // fill the FIFO, then reset asynchronously mid-cycle
    repeat (5)  step(1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_src_ready", 128'(src_ready), 128'(0));
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3)    step(0, 1'b1);
    repeat (3000) step(4, 1'b0);
`ifdef NOU_TX_ARB_PERF_EN
    repeat (70000) step(5, 1'b1);
    @(negedge clk);
    chk("perf_sat_src1", 128'(perf_grant[31:16]), 128'(16'hFFFF));
    // clear in the same cycle as a grant
    step(5, 1'b1);
    perf_clr = 1'b1;
    repeat (3) step(5, 1'b1);
`endif
    repeat (4) step(0, 1'b1);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
